// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller.
// FETCH_ALIGN_CHECK_EN adds the ERR state for misaligned fetch addresses.
package fetch_ctrl_pkg;

    localparam int          FETCH_ADDR_W   = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
    localparam logic        ENABLE         = 1'b1;
    localparam logic        DISABLE        = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        ERR
`endif
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Program counter with flush > branch > increment priority selection.
// Without FETCH_ALIGN_CHECK_EN the two low PC bits are held at zero.
module fetch_pc_sel
    import fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] pc
);

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] PC_MASK = '1;
`else
    localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(3);
`endif

    logic [ADDR_W-1:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (flush_i)
            pc_next = new_pc_i;
        else if (branch_flag_i)
            pc_next = branch_target_i;
        else if (inc_en)
            pc_next = pc + ADDR_W'(4);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pc <= RESET_PC & PC_MASK;
        else
            pc <= pc_next & PC_MASK;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: one outstanding fetch, stall hold, redirect with kill.
// FETCH_ALIGN_CHECK_EN enables the misaligned-PC ERR state and misalign_o.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              ce_o,
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              misalign_o
);

    fetch_state_t      state, state_next;
    logic              kill, kill_next;
    logic              deliver;
    logic              inc_en;
    logic              redirect;
    logic [ADDR_W-1:0] pc;

    fetch_pc_sel #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_sel (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .inc_en          (inc_en),
        .pc              (pc)
    );

    assign redirect    = flush_i | branch_flag_i;
    assign imem_addr_o = pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = (pc[1:0] != 2'b00);
    assign imem_req_o = (state == REQ) && !misaligned;
`else
    assign imem_req_o = (state == REQ);
`endif

    // A response that lands in the same cycle as a redirect belongs to the old path.
    always_comb begin
        state_next = state;
        kill_next  = kill;
        deliver    = DISABLE;
        inc_en     = DISABLE;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_req_o && imem_gnt_i) begin
                    state_next = WAIT;
                    kill_next  = redirect;
                end
`ifdef FETCH_ALIGN_CHECK_EN
                else if (misaligned && !redirect) begin
                    state_next = ERR;
                end
`endif
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    if (kill || redirect) begin
                        kill_next  = DISABLE;
                        state_next = REQ;
                    end else begin
                        deliver    = ENABLE;
                        state_next = HOLD;
                    end
                end else if (redirect) begin
                    kill_next = ENABLE;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_next = REQ;
                end else if (!stall_i) begin
                    inc_en     = ENABLE;
                    state_next = REQ;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            ERR: begin
                if (redirect)
                    state_next = REQ;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            kill         <= DISABLE;
            ce_o         <= DISABLE;
            inst_valid_o <= DISABLE;
            inst_o       <= ZERO_WORD;
            inst_pc_o    <= '0;
        end else begin
            state        <= state_next;
            kill         <= kill_next;
            ce_o         <= (state_next != IDLE);
            inst_valid_o <= (state_next == HOLD);
            if (deliver) begin
                inst_o    <= imem_rdata_i;
                inst_pc_o <= pc;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            misalign_o <= DISABLE;
        else
            misalign_o <= (state_next == ERR);
    end
`else
    assign misalign_o = DISABLE;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a zero-wait memory model and manual handshake mode.
// FETCH_ALIGN_CHECK_EN selects the matching expectations for the misaligned branch.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        ce_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        misalign_o;

    logic        auto_mode = 1'b1;
    logic        auto_rvalid = 1'b0;
    logic [31:0] auto_rdata = '0;
    logic        man_gnt = 1'b0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata = '0;

    int num_compared = 0;
    int num_mismatched = 0;

    fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .ce_o            (ce_o),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .misalign_o      (misalign_o)
    );

    always #5 clk = ~clk;

    // Zero-wait memory: grants any request, answers 0x1111_0000+addr next cycle.
    assign imem_gnt_i    = auto_mode ? imem_req_o : man_gnt;
    assign imem_rvalid_i = auto_mode ? auto_rvalid : man_rvalid;
    assign imem_rdata_i  = auto_mode ? auto_rdata : man_rdata;

    always @(posedge clk) begin
        auto_rvalid <= auto_mode && imem_req_o && imem_gnt_i;
        auto_rdata  <= 32'h1111_0000 + imem_addr_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values
        repeat (2) tick();
        check_output("rst_req", 32'(imem_req_o), 32'd0);
        check_output("rst_addr", imem_addr_o, 32'h0);
        check_output("rst_ce", 32'(ce_o), 32'd0);
        check_output("rst_valid", 32'(inst_valid_o), 32'd0);
        check_output("rst_inst", inst_o, 32'h0);
        check_output("rst_inst_pc", inst_pc_o, 32'h0);
        check_output("rst_misalign", 32'(misalign_o), 32'd0);

        // Sequential fetch, 3 cycles per instruction
        rst = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) stall_i = 1'b1;
            check_output($sformatf("seq_req_%0d", k), 32'(imem_req_o), 32'd1);
            check_output($sformatf("seq_addr_%0d", k), imem_addr_o, 32'(4 * k));
            check_output($sformatf("seq_ce_%0d", k), 32'(ce_o), 32'd1);
            tick();
            check_output($sformatf("seq_wait_req_%0d", k), 32'(imem_req_o), 32'd0);
            tick();
            check_output($sformatf("seq_valid_%0d", k), 32'(inst_valid_o), 32'd1);
            check_output($sformatf("seq_inst_pc_%0d", k), inst_pc_o, 32'(4 * k));
            check_output($sformatf("seq_inst_%0d", k), inst_o, 32'h1111_0000 + 32'(4 * k));
            if (k < 2) tick();
        end

        // Stall holds the instruction at 0x8
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output($sformatf("stall_valid_%0d", i), 32'(inst_valid_o), 32'd1);
            check_output($sformatf("stall_inst_%0d", i), inst_o, 32'h1111_0008);
            check_output($sformatf("stall_req_%0d", i), 32'(imem_req_o), 32'd0);
        end
        stall_i = 1'b0;
        tick();
        check_output("unstall_valid", 32'(inst_valid_o), 32'd0);
        check_output("unstall_addr", imem_addr_o, 32'h0000_000C);

        // Branch in the grant cycle of 0xC kills that fetch
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0100;
        tick();
        branch_flag_i = 1'b0;
        check_output("br_wait_req", 32'(imem_req_o), 32'd0);
        tick();
        check_output("br_killed_valid", 32'(inst_valid_o), 32'd0);
        check_output("br_req", 32'(imem_req_o), 32'd1);
        check_output("br_addr", imem_addr_o, 32'h0000_0100);
        repeat (2) tick();
        check_output("br_inst_pc", inst_pc_o, 32'h0000_0100);
        check_output("br_inst", inst_o, 32'h1111_0100);

        // Flush beats branch in HOLD, even while stalled
        stall_i         = 1'b1;
        flush_i         = 1'b1;
        new_pc_i        = 32'h0000_0180;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0100;
        tick();
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        branch_flag_i = 1'b0;
        check_output("fl_valid", 32'(inst_valid_o), 32'd0);
        check_output("fl_req", 32'(imem_req_o), 32'd1);
        check_output("fl_addr", imem_addr_o, 32'h0000_0180);
        repeat (2) tick();
        check_output("fl_inst_pc", inst_pc_o, 32'h0000_0180);

        // Manual handshake: ungranted redirect, redirect in WAIT
        auto_mode = 1'b0;
        tick();
        check_output("man_req", 32'(imem_req_o), 32'd1);
        check_output("man_addr", imem_addr_o, 32'h0000_0184);
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0040;
        tick();
        branch_flag_i = 1'b0;
        check_output("nogrant_req", 32'(imem_req_o), 32'd1);
        check_output("nogrant_addr", imem_addr_o, 32'h0000_0040);
        man_gnt = 1'b1;
        tick();
        man_gnt = 1'b0;
        check_output("man_wait_req", 32'(imem_req_o), 32'd0);
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0080;
        tick();
        branch_flag_i = 1'b0;
        check_output("wait_br_req", 32'(imem_req_o), 32'd0);
        check_output("wait_br_valid", 32'(inst_valid_o), 32'd0);
        man_rvalid = 1'b1;
        man_rdata  = 32'hBAD0_0040;
        tick();
        man_rvalid = 1'b0;
        check_output("wait_kill_valid", 32'(inst_valid_o), 32'd0);
        check_output("wait_kill_addr", imem_addr_o, 32'h0000_0080);
        check_output("wait_kill_req", 32'(imem_req_o), 32'd1);
        man_gnt = 1'b1;
        tick();
        man_gnt    = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'hCAFE_0080;
        tick();
        man_rvalid = 1'b0;
        check_output("man_valid", 32'(inst_valid_o), 32'd1);
        check_output("man_inst", inst_o, 32'hCAFE_0080);
        check_output("man_inst_pc", inst_pc_o, 32'h0000_0080);

        // Reset in WAIT, stale response after release
        tick();
        man_gnt = 1'b1;
        tick();
        man_gnt = 1'b0;
        rst = 1'b0;
        #1;
        check_output("midrst_req", 32'(imem_req_o), 32'd0);
        check_output("midrst_addr", imem_addr_o, 32'h0);
        check_output("midrst_ce", 32'(ce_o), 32'd0);
        check_output("midrst_valid", 32'(inst_valid_o), 32'd0);
        check_output("midrst_inst", inst_o, 32'h0);
        check_output("midrst_inst_pc", inst_pc_o, 32'h0);
        tick();
        rst        = 1'b1;
        man_rvalid = 1'b1;
        man_rdata  = 32'hDEAD_BEEF;
        tick();
        man_rvalid = 1'b0;
        check_output("stale_valid", 32'(inst_valid_o), 32'd0);
        check_output("stale_inst", inst_o, 32'h0);
        check_output("rel_req", 32'(imem_req_o), 32'd1);
        check_output("rel_addr", imem_addr_o, 32'h0);
        man_gnt = 1'b1;
        tick();
        man_gnt    = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'h0000_1234;
        tick();
        man_rvalid = 1'b0;
        check_output("rel_valid", 32'(inst_valid_o), 32'd1);
        check_output("rel_inst", inst_o, 32'h0000_1234);
        check_output("rel_inst_pc", inst_pc_o, 32'h0);

        // PC wraps past the top of the address space
        auto_mode = 1'b1;
        flush_i   = 1'b1;
        new_pc_i  = 32'hFFFF_FFFC;
        tick();
        flush_i = 1'b0;
        check_output("wrap_addr_top", imem_addr_o, 32'hFFFF_FFFC);
        repeat (2) tick();
        check_output("wrap_inst_pc", inst_pc_o, 32'hFFFF_FFFC);
        check_output("wrap_inst", inst_o, 32'h1110_FFFC);
        tick();
        check_output("wrap_addr_zero", imem_addr_o, 32'h0);
        repeat (2) tick();

        // Branch to a misaligned target
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0102;
        tick();
        branch_flag_i = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        check_output("mis_req_blocked", 32'(imem_req_o), 32'd0);
        tick();
        check_output("mis_flag", 32'(misalign_o), 32'd1);
        check_output("mis_err_req", 32'(imem_req_o), 32'd0);
        check_output("mis_err_valid", 32'(inst_valid_o), 32'd0);
        tick();
        check_output("mis_flag_hold", 32'(misalign_o), 32'd1);
        flush_i  = 1'b1;
        new_pc_i = 32'h0000_0200;
        tick();
        flush_i = 1'b0;
        check_output("mis_clear", 32'(misalign_o), 32'd0);
        check_output("mis_clear_req", 32'(imem_req_o), 32'd1);
        check_output("mis_clear_addr", imem_addr_o, 32'h0000_0200);
        repeat (2) tick();
        check_output("mis_inst_pc", inst_pc_o, 32'h0000_0200);
`else
        check_output("noalign_req", 32'(imem_req_o), 32'd1);
        check_output("noalign_addr", imem_addr_o, 32'h0000_0100);
        check_output("noalign_flag", 32'(misalign_o), 32'd0);
        repeat (2) tick();
        check_output("noalign_inst_pc", inst_pc_o, 32'h0000_0100);
        check_output("noalign_inst", inst_o, 32'h1111_0100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
